// File: rtl/riscv_hzrd_ctrl.sv
// Hazard and mul/div sequencing controller for the decode/execute boundary.
// Generates stall/flush controls and one-cycle start pulses for the multi-cycle units.
//
// state   | meaning
// IDLE    | no op in flight; mul/div start detected here; hazards evaluated
// MUL_RUN | multiplier busy for MUL_LAT cycles, pipeline held
// DIV_RUN | divider busy until div_done or DIV_TMO cycles, pipeline held
// DONE    | one release cycle; mul/div advances, hazards evaluated, no start
module riscv_hzrd_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_TMO = 64,
    parameter int CNT_W   = 7
) (
    input  logic       i_riscv_hz_clk,
    input  logic       i_riscv_hz_rst,
    input  logic [1:0] i_riscv_hz_funcsel_e,
    input  logic [1:0] i_riscv_hz_resultsrc_e,
    input  logic [4:0] i_riscv_hz_rdaddr_e,
    input  logic [4:0] i_riscv_hz_rs1addr_d,
    input  logic [4:0] i_riscv_hz_rs2addr_d,
    input  logic       i_riscv_hz_pcsrc_e,
    input  logic       i_riscv_hz_div_done,
    output logic       o_riscv_hz_mul_start,
    output logic       o_riscv_hz_div_start,
    output logic       o_riscv_hz_stallpc,
    output logic       o_riscv_hz_stallfd,
    output logic       o_riscv_hz_stallde,
    output logic       o_riscv_hz_flushfd,
    output logic       o_riscv_hz_flushde,
    output logic       o_riscv_hz_flushem,
    output logic       o_riscv_hz_busy,
    output logic       o_riscv_hz_div_tmo
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MUL_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_TMO - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             div_tmo;
    logic             div_tmo_nxt;

    logic is_mul;
    logic is_div;
    logic load_use;
    logic hazard_en;
    logic op_stall;

    logic mul_start_c;
    logic div_start_c;
    logic stallpc_c;
    logic stallfd_c;
    logic flushfd_c;
    logic flushde_c;
    logic busy_c;

    assign is_mul   = (i_riscv_hz_funcsel_e == 2'b01);
    assign is_div   = (i_riscv_hz_funcsel_e == 2'b10);
    assign load_use = (i_riscv_hz_resultsrc_e == 2'b01) && (i_riscv_hz_rdaddr_e != 5'd0) &&
                      ((i_riscv_hz_rs1addr_d == i_riscv_hz_rdaddr_e) ||
                       (i_riscv_hz_rs2addr_d == i_riscv_hz_rdaddr_e));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_tmo_nxt = div_tmo;
        mul_start_c = 1'b0;
        div_start_c = 1'b0;
        op_stall    = 1'b0;
        hazard_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mul) begin
                    mul_start_c = 1'b1;
                    op_stall    = 1'b1;
                    cnt_nxt     = MUL_INIT;
                    state_nxt   = S_MUL_RUN;
                end else if (is_div) begin
                    div_start_c = 1'b1;
                    op_stall    = 1'b1;
                    cnt_nxt     = DIV_INIT;
                    state_nxt   = S_DIV_RUN;
                end else begin
                    hazard_en = 1'b1;
                end
            end
            S_MUL_RUN: begin
                op_stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DIV_RUN: begin
                op_stall = 1'b1;
                // A result arriving on the last allowed cycle is a real completion, not a timeout.
                if (i_riscv_hz_div_done) begin
                    state_nxt = S_DONE;
                end else if (cnt == '0) begin
                    state_nxt   = S_DONE;
                    div_tmo_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                hazard_en = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stallpc_c = op_stall;
        stallfd_c = op_stall;
        flushfd_c = 1'b0;
        flushde_c = 1'b0;
        busy_c    = op_stall;
        if (hazard_en) begin
            if (i_riscv_hz_pcsrc_e) begin
                flushfd_c = 1'b1;
                flushde_c = 1'b1;
            end else if (load_use) begin
                stallpc_c = 1'b1;
                stallfd_c = 1'b1;
                flushde_c = 1'b1;
            end
        end
    end

    always_ff @(posedge i_riscv_hz_clk) begin
        if (i_riscv_hz_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_tmo <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_tmo <= div_tmo_nxt;
        end
    end

    // Reset masks every output so nothing leaks out while an op is being abandoned.
    assign o_riscv_hz_mul_start = mul_start_c & ~i_riscv_hz_rst;
    assign o_riscv_hz_div_start = div_start_c & ~i_riscv_hz_rst;
    assign o_riscv_hz_stallpc   = stallpc_c   & ~i_riscv_hz_rst;
    assign o_riscv_hz_stallfd   = stallfd_c   & ~i_riscv_hz_rst;
    assign o_riscv_hz_stallde   = op_stall    & ~i_riscv_hz_rst;
    assign o_riscv_hz_flushfd   = flushfd_c   & ~i_riscv_hz_rst;
    assign o_riscv_hz_flushde   = flushde_c   & ~i_riscv_hz_rst;
    assign o_riscv_hz_flushem   = op_stall    & ~i_riscv_hz_rst;
    assign o_riscv_hz_busy      = busy_c      & ~i_riscv_hz_rst;
    assign o_riscv_hz_div_tmo   = div_tmo     & ~i_riscv_hz_rst;

endmodule

// File: tb/tb_riscv_hzrd_ctrl.sv
// Bench for riscv_hzrd_ctrl: two instances (default and short divide timeout) share inputs
// and are compared every cycle against an elapsed-cycle model, plus directed literal checks.
module tb_riscv_hzrd_ctrl;

    localparam int LAT_A = 3;
    localparam int TMO_A = 64;
    localparam int LAT_B = 3;
    localparam int TMO_B = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] funcsel;
    logic [1:0] resultsrc;
    logic [4:0] rdaddr;
    logic [4:0] rs1addr;
    logic [4:0] rs2addr;
    logic       pcsrc;
    logic       div_done;

    logic a_mul_start, a_div_start, a_stallpc, a_stallfd, a_stallde;
    logic a_flushfd, a_flushde, a_flushem, a_busy, a_div_tmo;
    logic b_mul_start, b_div_start, b_stallpc, b_stallfd, b_stallde;
    logic b_flushfd, b_flushde, b_flushem, b_busy, b_div_tmo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_hzrd_ctrl #(.MUL_LAT(LAT_A), .DIV_TMO(TMO_A), .CNT_W(7)) u_a (
        .i_riscv_hz_clk(clk), .i_riscv_hz_rst(rst),
        .i_riscv_hz_funcsel_e(funcsel), .i_riscv_hz_resultsrc_e(resultsrc),
        .i_riscv_hz_rdaddr_e(rdaddr), .i_riscv_hz_rs1addr_d(rs1addr),
        .i_riscv_hz_rs2addr_d(rs2addr), .i_riscv_hz_pcsrc_e(pcsrc),
        .i_riscv_hz_div_done(div_done),
        .o_riscv_hz_mul_start(a_mul_start), .o_riscv_hz_div_start(a_div_start),
        .o_riscv_hz_stallpc(a_stallpc), .o_riscv_hz_stallfd(a_stallfd),
        .o_riscv_hz_stallde(a_stallde), .o_riscv_hz_flushfd(a_flushfd),
        .o_riscv_hz_flushde(a_flushde), .o_riscv_hz_flushem(a_flushem),
        .o_riscv_hz_busy(a_busy), .o_riscv_hz_div_tmo(a_div_tmo));

    riscv_hzrd_ctrl #(.MUL_LAT(LAT_B), .DIV_TMO(TMO_B), .CNT_W(7)) u_b (
        .i_riscv_hz_clk(clk), .i_riscv_hz_rst(rst),
        .i_riscv_hz_funcsel_e(funcsel), .i_riscv_hz_resultsrc_e(resultsrc),
        .i_riscv_hz_rdaddr_e(rdaddr), .i_riscv_hz_rs1addr_d(rs1addr),
        .i_riscv_hz_rs2addr_d(rs2addr), .i_riscv_hz_pcsrc_e(pcsrc),
        .i_riscv_hz_div_done(div_done),
        .o_riscv_hz_mul_start(b_mul_start), .o_riscv_hz_div_start(b_div_start),
        .o_riscv_hz_stallpc(b_stallpc), .o_riscv_hz_stallfd(b_stallfd),
        .o_riscv_hz_stallde(b_stallde), .o_riscv_hz_flushfd(b_flushfd),
        .o_riscv_hz_flushde(b_flushde), .o_riscv_hz_flushem(b_flushem),
        .o_riscv_hz_busy(b_busy), .o_riscv_hz_div_tmo(b_div_tmo));

    logic [9:0] a_vec, b_vec;
    assign a_vec = {a_mul_start, a_div_start, a_stallpc, a_stallfd, a_stallde,
                    a_flushfd, a_flushde, a_flushem, a_busy, a_div_tmo};
    assign b_vec = {b_mul_start, b_div_start, b_stallpc, b_stallfd, b_stallde,
                    b_flushfd, b_flushde, b_flushem, b_busy, b_div_tmo};

    // Model: op = 0 none / 1 mul / 2 div in flight; runs = run cycles completed;
    // rel = this cycle is the release cycle after an op; tmo = sticky timeout.
    typedef struct {
        int op;
        int runs;
        bit rel;
        bit tmo;
    } mdl_t;

    mdl_t ma, mb;
    bit   valid = 1'b0;

    function automatic logic [9:0] model_out(mdl_t m);
        logic ms, ds, spc, sfd, sde, ffd, fde, fem, bsy;
        logic lu;
        {ms, ds, spc, sfd, sde, ffd, fde, fem, bsy} = '0;
        lu = (resultsrc == 2'b01) && (rdaddr != 0) && (rs1addr == rdaddr || rs2addr == rdaddr);
        if (rst) return 10'd0;
        if (m.op != 0) begin
            {spc, sfd, sde, fem, bsy} = '1;
        end else if (!m.rel && (funcsel == 2'b01 || funcsel == 2'b10)) begin
            ms = (funcsel == 2'b01);
            ds = (funcsel == 2'b10);
            {spc, sfd, sde, fem, bsy} = '1;
        end else if (pcsrc) begin
            ffd = 1'b1;
            fde = 1'b1;
        end else if (lu) begin
            spc = 1'b1;
            sfd = 1'b1;
            fde = 1'b1;
        end
        return {ms, ds, spc, sfd, sde, ffd, fde, fem, bsy, m.tmo};
    endfunction

    function automatic mdl_t model_step(mdl_t m, int lat, int tmo_lim);
        mdl_t n = m;
        if (rst) begin
            n.op = 0; n.runs = 0; n.rel = 1'b0; n.tmo = 1'b0;
        end else if (m.op != 0) begin
            n.runs = m.runs + 1;
            if (m.op == 1 && n.runs >= lat) begin
                n.op = 0; n.rel = 1'b1;
            end else if (m.op == 2 && div_done) begin
                n.op = 0; n.rel = 1'b1;
            end else if (m.op == 2 && n.runs >= tmo_lim) begin
                n.op = 0; n.rel = 1'b1; n.tmo = 1'b1;
            end
        end else if (m.rel) begin
            n.rel = 1'b0;
        end else if (funcsel == 2'b01) begin
            n.op = 1; n.runs = 0;
        end else if (funcsel == 2'b10) begin
            n.op = 2; n.runs = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) valid <= 1'b1;
        ma <= model_step(ma, LAT_A, TMO_A);
        mb <= model_step(mb, LAT_B, TMO_B);
    end

    always @(negedge clk) begin
        if (valid) begin
            n_tests++;
            if (a_vec !== model_out(ma)) begin
                n_fail++;
                $display("FAIL model_a t=%0t got=%b exp=%b", $time, a_vec, model_out(ma));
            end
            n_tests++;
            if (b_vec !== model_out(mb)) begin
                n_fail++;
                $display("FAIL model_b t=%0t got=%b exp=%b", $time, b_vec, model_out(mb));
            end
        end
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; funcsel = 2'b01; resultsrc = 2'b00; rdaddr = 5'd0;
        rs1addr = 5'd0; rs2addr = 5'd0; pcsrc = 1'b0; div_done = 1'b0;
        next_cyc();
        repeat (2) begin
            @(negedge clk);
            chk("rst_quiet", a_vec, 10'd0);
            next_cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mul_start", {a_mul_start, a_stallde, a_flushem, a_busy}, 4'b1111);
        next_cyc();
        funcsel = 2'b00; pcsrc = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mul_run", {a_mul_start, a_stallde, a_flushem, a_flushfd, a_flushde}, 5'b01100);
            next_cyc();
        end
        pcsrc = 1'b0;
        @(negedge clk);
        chk("mul_done", {a_stallpc, a_stallde, a_flushem, a_busy}, 4'b0000);
        next_cyc();
        pcsrc = 1'b1;
        @(negedge clk);
        chk("branch_idle", {a_flushfd, a_flushde, a_stallpc}, 3'b110);
        next_cyc();
        pcsrc = 1'b0; resultsrc = 2'b01; rdaddr = 5'd5; rs1addr = 5'd1; rs2addr = 5'd5;
        @(negedge clk);
        chk("load_use", {a_stallpc, a_stallfd, a_flushde, a_stallde}, 4'b1110);
        next_cyc();
        rdaddr = 5'd0; rs1addr = 5'd0; rs2addr = 5'd0;
        @(negedge clk);
        chk("load_x0", {a_stallpc, a_stallfd, a_flushde}, 3'b000);
        next_cyc();
        resultsrc = 2'b00; funcsel = 2'b10;
        @(negedge clk);
        chk("div_start", {a_div_start, a_stallde}, 2'b11);
        next_cyc();
        funcsel = 2'b00;
        repeat (9) begin
            @(negedge clk);
            chk("div_run", {a_div_start, a_stallde}, 2'b01);
            next_cyc();
        end
        div_done = 1'b1;
        @(negedge clk);
        chk("div_last", a_stallde, 1'b1);
        next_cyc();
        div_done = 1'b0;
        @(negedge clk);
        chk("div_done", {a_stallde, a_busy, a_div_tmo, b_div_tmo}, 4'b0001);
        next_cyc();
        funcsel = 2'b10;
        @(negedge clk);
        chk("tmo_sticky", {b_div_tmo, a_div_start}, 2'b11);
        next_cyc();
        funcsel = 2'b00;
        repeat (33) begin
            @(negedge clk);
            chk("div_long", a_stallde, 1'b1);
            next_cyc();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_a", a_vec, 10'd0);
        chk("rst_mid_b", b_vec, 10'd0);
        next_cyc();
        rst = 1'b0; div_done = 1'b1;
        @(negedge clk);
        chk("after_rst", {a_busy, a_stallde, a_div_start, b_div_tmo}, 4'b0000);
        next_cyc();
        div_done = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            int r;
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 15);
            funcsel   = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            div_done  = ($urandom_range(0, 9) == 0);
            resultsrc = 2'($urandom_range(0, 3));
            rdaddr    = 5'($urandom_range(0, 3));
            rs1addr   = 5'($urandom_range(0, 3));
            rs2addr   = 5'($urandom_range(0, 3));
            pcsrc     = ($urandom_range(0, 3) == 0);
            next_cyc();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
